// File: rtl/fb_port_arbiter.sv
// Frame buffer port arbiter: display reads always win the single RAM port, and
// writer pixels wait in a small FIFO that drains into cycles the display leaves unused.
module fb_port_arbiter #(
  parameter int ADDR_W     = 17,
  parameter int DATA_W     = 12,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            disp_rd_en,
  input  logic [ADDR_W-1:0]               disp_rd_addr,
  output logic [DATA_W-1:0]               disp_rd_data,
  output logic                            disp_rd_valid,
  input  logic                            wr_valid,
  output logic                            wr_ready,
  input  logic [ADDR_W-1:0]               wr_addr,
  input  logic [DATA_W-1:0]               wr_data,
  output logic                            ram_en,
  output logic                            ram_we,
  output logic [ADDR_W-1:0]               ram_addr,
  output logic [DATA_W-1:0]               ram_wdata,
  input  logic [DATA_W-1:0]               ram_rdata,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_count,
  output logic                            idle
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] fifo_addr [FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic              push;
  logic              pop;
  logic              rd_return;

  // Ready looks only at the registered count, never at a same-cycle pop.
  assign wr_ready = (fifo_count < CNT_W'(FIFO_DEPTH));
  assign push     = wr_valid && wr_ready;
  assign pop      = !disp_rd_en && (fifo_count != '0);

  assign idle = (fifo_count == '0) && !ram_en && !rd_return;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr] <= wr_addr;
      fifo_data[wr_ptr] <= wr_data;
    end
  end

  // Power-of-two depth lets the pointers wrap naturally.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)
        fifo_count <= fifo_count + CNT_W'(1);
      else if (pop && !push)
        fifo_count <= fifo_count - CNT_W'(1);
    end
  end

  // Address and write data hold their last value on cycles with no RAM access.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ram_en    <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
    end else if (disp_rd_en) begin
      ram_en   <= 1'b1;
      ram_we   <= 1'b0;
      ram_addr <= disp_rd_addr;
    end else if (pop) begin
      ram_en    <= 1'b1;
      ram_we    <= 1'b1;
      ram_addr  <= fifo_addr[rd_ptr];
      ram_wdata <= fifo_data[rd_ptr];
    end else begin
      ram_en <= 1'b0;
      ram_we <= 1'b0;
    end
  end

  // rd_return marks the cycle the RAM is driving read data back to us.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_return     <= 1'b0;
      disp_rd_valid <= 1'b0;
      disp_rd_data  <= '0;
    end else begin
      rd_return     <= ram_en && !ram_we;
      disp_rd_valid <= rd_return;
      if (rd_return) disp_rd_data <= ram_rdata;
    end
  end

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Self-checking bench for fb_port_arbiter: a transaction-level model (write queue,
// shadow memory, read-latency pipeline) is compared against the DUT every cycle.
module tb_fb_port_arbiter;

  localparam int ADDR_W = 17;
  localparam int DATA_W = 12;
  localparam int DEPTH  = 4;
  localparam int MEM_N  = 1 << ADDR_W;

  logic              clk;
  logic              reset_n;
  logic              disp_rd_en;
  logic [ADDR_W-1:0] disp_rd_addr;
  logic [DATA_W-1:0] disp_rd_data;
  logic              disp_rd_valid;
  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata = '0;
  logic [2:0]        fifo_count;
  logic              idle;

  fb_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n),
    .disp_rd_en(disp_rd_en), .disp_rd_addr(disp_rd_addr),
    .disp_rd_data(disp_rd_data), .disp_rd_valid(disp_rd_valid),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .fifo_count(fifo_count), .idle(idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] init_val(input logic [ADDR_W-1:0] a);
    if (a == 17'd5) return 12'hABC;
    return 12'(a * 73 + 501);
  endfunction

  // Synchronous single-port RAM; unwritten words read back their initial pattern.
  logic [DATA_W-1:0] mem [MEM_N];
  bit                written [MEM_N];
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) begin
        mem[ram_addr]     <= ram_wdata;
        written[ram_addr] <= 1'b1;
      end else begin
        ram_rdata <= written[ram_addr] ? mem[ram_addr] : init_val(ram_addr);
      end
    end
  end

  typedef struct packed {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
  } wr_t;

  wr_t               q[$];
  logic [DATA_W-1:0] shadow [MEM_N];
  bit                pend_v;
  wr_t               pend;
  bit                p0_v, p1_v;
  logic [DATA_W-1:0] p0_d, p1_d;
  bit                model_accept;
  logic              exp_en, exp_we, exp_valid, exp_ready, exp_idle;
  logic [ADDR_W-1:0] exp_addr;
  logic [DATA_W-1:0] exp_wdata, exp_data;
  int                exp_count;
  logic [ADDR_W-1:0] wr_log[$];
  int                checks = 0;
  int                errors = 0;
  int                k;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic updateDerived();
    exp_count = q.size();
    exp_ready = (q.size() < DEPTH);
    exp_idle  = (q.size() == 0) && !exp_en && !p1_v;
  endtask

  task automatic modelReset();
    q.delete();
    pend_v = 0; p0_v = 0; p1_v = 0;
    exp_en = 0; exp_we = 0; exp_addr = '0; exp_wdata = '0;
    exp_valid = 0; exp_data = '0;
    model_accept = 0;
    updateDerived();
  endtask

  // Advance the model by one clock edge using the inputs the DUT will sample there.
  task automatic modelStep();
    wr_t w;
    if (!reset_n) begin
      modelReset();
      return;
    end
    if (pend_v) shadow[pend.a] = pend.d;
    pend_v = 0;
    exp_valid = p1_v;
    if (p1_v) exp_data = p1_d;
    p1_v = p0_v; p1_d = p0_d;
    p0_v = 0;
    model_accept = wr_valid && (q.size() < DEPTH);
    if (disp_rd_en) begin
      exp_en = 1; exp_we = 0; exp_addr = disp_rd_addr;
      p0_v = 1; p0_d = shadow[disp_rd_addr];
    end else if (q.size() > 0) begin
      w = q.pop_front();
      exp_en = 1; exp_we = 1; exp_addr = w.a; exp_wdata = w.d;
      pend = w; pend_v = 1;
    end else begin
      exp_en = 0; exp_we = 0;
    end
    if (model_accept) begin
      w.a = wr_addr; w.d = wr_data;
      q.push_back(w);
    end
    updateDerived();
  endtask

  task automatic checkOutput();
    check("ram_en", 32'(ram_en), 32'(exp_en));
    check("ram_we", 32'(ram_we), 32'(exp_we));
    check("ram_addr", 32'(ram_addr), 32'(exp_addr));
    check("ram_wdata", 32'(ram_wdata), 32'(exp_wdata));
    check("disp_rd_valid", 32'(disp_rd_valid), 32'(exp_valid));
    check("disp_rd_data", 32'(disp_rd_data), 32'(exp_data));
    check("fifo_count", 32'(fifo_count), 32'(exp_count));
    check("wr_ready", 32'(wr_ready), 32'(exp_ready));
    check("idle", 32'(idle), 32'(exp_idle));
    if (ram_en && ram_we) wr_log.push_back(ram_addr);
  endtask

  task automatic applyStimulus(input bit rd, input int ra, input bit wv, input int wa,
                               input int wd);
    disp_rd_en   = rd;
    disp_rd_addr = ADDR_W'(ra);
    wr_valid     = wv;
    wr_addr      = ADDR_W'(wa);
    wr_data      = DATA_W'(wd);
    modelStep();
    @(negedge clk);
    checkOutput();
  endtask

  initial begin
    for (int i = 0; i < MEM_N; i++) shadow[i] = init_val(ADDR_W'(i));
    reset_n = 1'b1;
    disp_rd_en = 1'b1; disp_rd_addr = 17'd7;
    wr_valid = 1'b1; wr_addr = 17'd9; wr_data = 12'h555;
    #1 reset_n = 1'b0;
    modelReset();
    repeat (3) @(negedge clk);
    checkOutput();
    check("rst_ram_en", 32'(ram_en), 0);
    check("rst_wr_ready", 32'(wr_ready), 1);
    check("rst_idle", 32'(idle), 1);
    check("rst_count", 32'(fifo_count), 0);

    reset_n = 1'b1;
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
    check("post_rst_idle", 32'(idle), 1);
    check("post_rst_ram_en", 32'(ram_en), 0);

    // Single read then three back-to-back reads.
    applyStimulus(1, 5, 0, 0, 0);
    check("rd_cmd_en", 32'(ram_en), 1);
    check("rd_cmd_we", 32'(ram_we), 0);
    check("rd_cmd_addr", 32'(ram_addr), 5);
    applyStimulus(0, 0, 0, 0, 0);
    check("rd_lat1_valid", 32'(disp_rd_valid), 0);
    applyStimulus(0, 0, 0, 0, 0);
    check("rd_valid", 32'(disp_rd_valid), 1);
    check("rd_data", 32'(disp_rd_data), 32'hABC);
    applyStimulus(1, 10, 0, 0, 0);
    applyStimulus(1, 11, 0, 0, 0);
    applyStimulus(1, 12, 0, 0, 0);
    check("b2b_valid0", 32'(disp_rd_valid), 1);
    applyStimulus(0, 0, 0, 0, 0);
    check("b2b_valid1", 32'(disp_rd_valid), 1);
    applyStimulus(0, 0, 0, 0, 0);
    check("b2b_valid2", 32'(disp_rd_valid), 1);
    applyStimulus(0, 0, 0, 0, 0);
    check("b2b_valid3", 32'(disp_rd_valid), 0);

    // Write into an idle port.
    wr_log.delete();
    applyStimulus(0, 0, 1, 100, 'h123);
    check("iw_count1", 32'(fifo_count), 1);
    check("iw_no_en", 32'(ram_en), 0);
    applyStimulus(0, 0, 0, 0, 0);
    check("iw_we", 32'(ram_we), 1);
    check("iw_addr", 32'(ram_addr), 100);
    check("iw_wdata", 32'(ram_wdata), 32'h123);
    check("iw_count0", 32'(fifo_count), 0);
    applyStimulus(0, 0, 0, 0, 0);
    check("iw_idle", 32'(idle), 1);

    // Display holds the port while the writer offers addr 1..5.
    wr_log.delete();
    k = 1;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1, 20 + i, k <= 5, k, 'h200 + k);
      if (model_accept) k++;
    end
    check("cont_count", 32'(fifo_count), 4);
    check("cont_ready", 32'(wr_ready), 0);
    check("cont_no_we", 32'(wr_log.size()), 0);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(0, 0, k <= 5, k, 'h200 + k);
      if (model_accept) k++;
    end
    check("cont_nwrites", 32'(wr_log.size()), 5);
    for (int i = 0; i < 5 && i < wr_log.size(); i++)
      check("cont_order", 32'(wr_log[i]), 32'(i + 1));

    // Simultaneous push and pop.
    wr_log.delete();
    applyStimulus(1, 30, 1, 40, 'h040);
    applyStimulus(1, 31, 1, 41, 'h041);
    applyStimulus(1, 32, 1, 42, 'h042);
    check("pp_count3", 32'(fifo_count), 3);
    applyStimulus(0, 0, 1, 43, 'h043);
    check("pp_count_hold", 32'(fifo_count), 3);
    applyStimulus(1, 33, 1, 44, 'h044);
    check("pp_count4", 32'(fifo_count), 4);
    check("pp_ready0", 32'(wr_ready), 0);
    applyStimulus(0, 0, 1, 45, 'h045);
    check("pp_blocked", 32'(fifo_count), 3);
    repeat (4) applyStimulus(0, 0, 0, 0, 0);
    check("pp_nwrites", 32'(wr_log.size()), 5);
    for (int i = 0; i < 5 && i < wr_log.size(); i++)
      check("pp_order", 32'(wr_log[i]), 32'(40 + i));

    // Reset with writes queued and a read in flight.
    applyStimulus(1, 50, 1, 60, 'h060);
    applyStimulus(1, 51, 1, 61, 'h061);
    applyStimulus(1, 52, 1, 62, 'h062);
    check("md_count3", 32'(fifo_count), 3);
    reset_n = 1'b0;
    #1;
    modelReset();
    check("md_count0", 32'(fifo_count), 0);
    check("md_ram_en", 32'(ram_en), 0);
    check("md_valid", 32'(disp_rd_valid), 0);
    check("md_idle", 32'(idle), 1);
    wr_log.delete();
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
    reset_n = 1'b1;
    repeat (4) applyStimulus(0, 0, 0, 0, 0);
    check("md_no_stale", 32'(wr_log.size()), 0);

    // Randomized traffic with display bursts and occasional resets.
    begin
      bit burst = 0;
      for (int i = 0; i < 3000; i++) begin
        if ($urandom_range(0, 19) == 0) burst = !burst;
        reset_n = ($urandom_range(0, 499) != 0);
        applyStimulus($urandom_range(0, 99) < (burst ? 90 : 25),
                      int'($urandom_range(0, 63)),
                      $urandom_range(0, 2) != 0,
                      int'($urandom_range(0, 63)),
                      int'($urandom_range(0, 4095)));
      end
    end
    reset_n = 1'b1;
    repeat (8) applyStimulus(0, 0, 0, 0, 0);
    check("final_idle", 32'(idle), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
